somador2comp_uc: RTL and testbench
==================================

# somador2comp_uc

Control unit and result decoder for the two's-complement adder datapath. A sequencer FSM starts on an `iniciar` request and issues the datapath's six one-cycle load/compute strobes in order. It then captures the datapath's sign-magnitude result (`{sinal, magnitude}`), converts it to an (N+1)-bit two's-complement sum, and signals completion with `pronto`. It sits between the top-level request source and the adder datapath.

## Interface
- `N`, default 5: datapath operand width. The result input is N+1 bits; the decoded sum is N+1 bits.
- `clk` input 1: single system clock, rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `iniciar` input 1: start request, sampled only in IDLE.
- `result_sm` input N+1: datapath result, `[N]` = sign, `[N-1:0]` = magnitude.
- `loadAB` output 1: datapath strobe, latch operands.
- `loadmagAB` output 1: datapath strobe, compute magnitudes.
- `comp_mag` output 1: datapath strobe, order magnitudes.
- `comp_sinais` output 1: datapath strobe, select operation and sign.
- `soma_sub` output 1: datapath strobe, add/subtract magnitudes.
- `loadRES` output 1: datapath strobe, register result.
- `soma` output N+1: decoded two's-complement sum, registered.
- `pronto` output 1: one-cycle completion pulse; `soma` is valid.
- `ocupado` output 1: high whenever state ≠ IDLE.
- `n_ops` output 8: count of completed operations, wraps.

## Operation
- States and sequence: IDLE → LOAD_AB → LOAD_MAG → COMP_MAG → COMP_SIN → SOMA_SUB → LOAD_RES → CAPTURA → DONE → IDLE.
- IDLE:
  - `iniciar`=1 at a clock edge → LOAD_AB; otherwise stay.
  - `iniciar` is ignored in every other state; there is no queuing.
- Strobes are Moore outputs, one state each: LOAD_AB→`loadAB`, LOAD_MAG→`loadmagAB`, COMP_MAG→`comp_mag`, COMP_SIN→`comp_sinais`, SOMA_SUB→`soma_sub`, LOAD_RES→`loadRES`.
  - At most one strobe is high in any cycle.
  - All strobes are 0 in IDLE, CAPTURA and DONE.
- CAPTURA: registers the decoded `result_sm` into `soma`.
  - sign=0: `soma` = {1'b0, mag}.
  - sign=1, mag≠0: `soma` = (~{1'b0, mag}) + 1, modulo 2^(N+1).
  - sign=1, mag=0 (negative zero): `soma` = 0.
  - mag uses all N bits, including the datapath carry bit; there is no overflow flag because N+1 bits always suffice.
- DONE:
  - `pronto`=1 for exactly one cycle.
  - `n_ops` increments by 1 (255→0 wrap).
  - Unconditional transition → IDLE.
- `soma` holds its value until the next CAPTURA.
- Illegal or unused state encodings → IDLE on the next edge, with all strobes low.

## Timing
- Reset values: state=IDLE, all strobes 0, `soma`=0, `pronto`=0, `ocupado`=0, `n_ops`=0.
- `RESET` takes priority over every other input, in any state, including mid-sequence.
  - Reset abandons the operation: no `pronto` and no `n_ops` increment.
  - The datapath's partially loaded registers are simply overwritten by the next run.
- Latency, with `iniciar` sampled high at edge 0:
  - `loadAB` high in cycle 1 (between edges 0 and 1).
  - `loadmagAB` in cycle 2, `comp_mag` in 3, `comp_sinais` in 4, `soma_sub` in 5, `loadRES` in 6.
  - CAPTURA in cycle 7; `result_sm` is stable from edge 6.
  - `soma` updates at edge 7; DONE/`pronto`=1 in cycle 8.
  - IDLE in cycle 9.
- Throughput: with `iniciar` held high, one operation per 9 cycles; `loadAB` pulses in cycles 1, 10, 19, ...
- `ocupado` is high in cycles 1–8, and also during DONE.
- `iniciar` must be applied with operand inputs stable at the datapath by edge 1.

## Test plan
- Positive sum, N=5: reset, then `iniciar` pulse; drive `result_sm`=6'b0_00111 from cycle 6.
  - Required: strobes in order in cycles 1–6, one-hot; `soma`=6'b000111 (7); `pronto` in cycle 8 only; `n_ops`=1.
- Negative decode: `result_sm`=6'b1_00011 → `soma`=6'b111101 (−3).
  - Also `result_sm`=6'b1_11000 → `soma`=6'b101000 (−24).
- Negative zero: `result_sm`=6'b1_00000 → `soma`=6'b000000.
- Reset mid-operation: assert `RESET` during cycle 4 (`comp_sinais` high).
  - Next cycle: all strobes 0, `ocupado`=0, `soma`=0, `n_ops` unchanged.
  - A subsequent `iniciar` completes normally.
- Back-to-back and ignored start:
  - Hold `iniciar`=1 for 30 cycles → `loadAB` in cycles 1, 10, 19, 28; `pronto` in cycles 8, 17, 26.
  - An `iniciar` pulse only in cycle 3 of a run → no extra run.
- Counter wrap: run 256 operations → `n_ops` reads 255 after the 255th, then 0 after the 256th; `soma` is unaffected.

Source files
------------

// File: rtl/somador2comp_uc.sv
// somador2comp_uc: sequencer and sign-magnitude to two's-complement decoder
// for the two's-complement adder datapath.
module somador2comp_uc #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         iniciar,
    input  logic [N:0]   result_sm,
    output logic         loadAB,
    output logic         loadmagAB,
    output logic         comp_mag,
    output logic         comp_sinais,
    output logic         soma_sub,
    output logic         loadRES,
    output logic [N:0]   soma,
    output logic         pronto,
    output logic         ocupado,
    output logic [7:0]   n_ops
);

    localparam int unsigned W      = N + 1;
    localparam int unsigned NSTB   = 6;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD_AB  = 4'd1,
        S_LOAD_MAG = 4'd2,
        S_COMP_MAG = 4'd3,
        S_COMP_SIN = 4'd4,
        S_SOMA_SUB = 4'd5,
        S_LOAD_RES = 4'd6,
        S_CAPTURA  = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NSTB-1:0]     w_strobe;
    logic [NSTB-1:0]     r_strobe;
    logic [W-1:0]        w_soma_dec;
    logic [N-1:0]        w_mag;
    logic                w_sign;
    logic [W-1:0]        r_soma;
    logic                r_pronto;
    logic                r_ocupado;
    logic [CNT_W-1:0]    r_n_ops;

    // State register
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:     w_next = iniciar ? S_LOAD_AB : S_IDLE;
            S_LOAD_AB:  w_next = S_LOAD_MAG;
            S_LOAD_MAG: w_next = S_COMP_MAG;
            S_COMP_MAG: w_next = S_COMP_SIN;
            S_COMP_SIN: w_next = S_SOMA_SUB;
            S_SOMA_SUB: w_next = S_LOAD_RES;
            S_LOAD_RES: w_next = S_CAPTURA;
            S_CAPTURA:  w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Strobe decode from the upcoming state so registered strobes line up with the state
    always_comb begin
        w_strobe = '0;
        case (w_next)
            S_LOAD_AB:  w_strobe = 6'b100000;
            S_LOAD_MAG: w_strobe = 6'b010000;
            S_COMP_MAG: w_strobe = 6'b001000;
            S_COMP_SIN: w_strobe = 6'b000100;
            S_SOMA_SUB: w_strobe = 6'b000010;
            S_LOAD_RES: w_strobe = 6'b000001;
            default:    w_strobe = '0;
        endcase
    end

    // Sign-magnitude to two's complement; negative zero maps to zero
    always_comb begin
        w_sign     = result_sm[N];
        w_mag      = result_sm[N-1:0];
        w_soma_dec = {1'b0, w_mag};
        if (w_sign && (w_mag != '0)) begin
            w_soma_dec = W'(~{1'b0, w_mag} + W'(1));
        end
    end

    // Registered outputs: strobes, status, captured sum and op counter
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_strobe  <= '0;
            r_soma    <= '0;
            r_pronto  <= 1'b0;
            r_ocupado <= 1'b0;
            r_n_ops   <= '0;
        end else begin
            r_strobe  <= w_strobe;
            r_pronto  <= (w_next == S_DONE);
            r_ocupado <= (w_next != S_IDLE);
            if (r_state == S_CAPTURA) begin
                r_soma <= w_soma_dec;
            end
            if (w_next == S_DONE) begin
                r_n_ops <= r_n_ops + CNT_W'(1);
            end
        end
    end

    assign loadAB      = r_strobe[5];
    assign loadmagAB   = r_strobe[4];
    assign comp_mag    = r_strobe[3];
    assign comp_sinais = r_strobe[2];
    assign soma_sub    = r_strobe[1];
    assign loadRES     = r_strobe[0];
    assign soma        = r_soma;
    assign pronto      = r_pronto;
    assign ocupado     = r_ocupado;
    assign n_ops       = r_n_ops;

endmodule

// File: tb/tb_somador2comp_uc.sv
// Directed bench for somador2comp_uc with a scoreboard queue of expected sums.
module tb_somador2comp_uc;

    localparam int unsigned N = 5;

    logic         clk;
    logic         RESET;
    logic         iniciar;
    logic [N:0]   result_sm;
    logic         loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub, loadRES;
    logic [N:0]   soma;
    logic         pronto;
    logic         ocupado;
    logic [7:0]   n_ops;
    logic [5:0]   strobes;

    int           checks = 0;
    int           errors = 0;
    logic [N:0]   sb_q[$];
    logic [7:0]   nops_model = 8'd0;

    somador2comp_uc #(.N(N)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .iniciar     (iniciar),
        .result_sm   (result_sm),
        .loadAB      (loadAB),
        .loadmagAB   (loadmagAB),
        .comp_mag    (comp_mag),
        .comp_sinais (comp_sinais),
        .soma_sub    (soma_sub),
        .loadRES     (loadRES),
        .soma        (soma),
        .pronto      (pronto),
        .ocupado     (ocupado),
        .n_ops       (n_ops)
    );

    assign strobes = {loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub, loadRES};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode, written arithmetically
    function automatic logic [N:0] ref_decode(input logic [N:0] rsm);
        int mag;
        mag = int'(rsm[N-1:0]);
        if (rsm[N] && mag != 0) return (N+1)'((1 << (N+1)) - mag);
        return (N+1)'(mag);
    endfunction

    // Completion: pop scoreboard and compare sum and counter
    task automatic handle_done(input string tag);
        logic [N:0] exp_s;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            exp_s = sb_q.pop_front();
            chk({tag, "_soma"}, 32'(soma), 32'(exp_s));
        end
        nops_model = nops_model + 8'd1;
        chk({tag, "_n_ops"}, 32'(n_ops), 32'(nops_model));
    endtask

    // One fully checked operation; ign_pulse raises iniciar during cycle 3
    task automatic run_op(input string tag, input logic [N:0] rsm, input logic [N:0] exp_s,
                          input bit ign_pulse);
        int seen;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk({tag, "_strobe"}, 32'(strobes), 32'(6'b100000 >> (k - 1)));
            chk({tag, "_ocupado"}, 32'(ocupado), 32'd1);
            if (ign_pulse && k == 3) iniciar = 1'b1;
            if (ign_pulse && k == 4) iniciar = 1'b0;
            if (k == 6) begin
                result_sm = rsm;
                sb_q.push_back(exp_s);
            end
            tick();
        end
        chk({tag, "_c7_strobe"}, 32'(strobes), 32'd0);
        chk({tag, "_c7_pronto"}, 32'(pronto), 32'd0);
        tick();
        chk({tag, "_c8_pronto"}, 32'(pronto), 32'd1);
        chk({tag, "_c8_ocupado"}, 32'(ocupado), 32'd1);
        handle_done(tag);
        tick();
        chk({tag, "_c9_pronto"}, 32'(pronto), 32'd0);
        chk({tag, "_c9_ocupado"}, 32'(ocupado), 32'd0);
        if (ign_pulse) begin
            seen = 0;
            for (int j = 0; j < 10; j++) begin
                if (loadAB || ocupado) seen++;
                tick();
            end
            chk({tag, "_no_extra_run"}, 32'(seen), 32'd0);
        end
    endtask

    initial begin
        logic [N:0] r;
        int         waited;
        RESET     = 1'b1;
        iniciar   = 1'b0;
        result_sm = '0;
        tick();
        tick();
        chk("rst_strobes", 32'(strobes), 32'd0);
        chk("rst_soma", 32'(soma), 32'd0);
        chk("rst_pronto", 32'(pronto), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_n_ops", 32'(n_ops), 32'd0);
        RESET = 1'b0;
        tick();
        chk("idle_ocupado", 32'(ocupado), 32'd0);

        // Reset in the middle of a run, during cycle 4
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst_comp_sinais", 32'(comp_sinais), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrst_strobes", 32'(strobes), 32'd0);
        chk("midrst_ocupado", 32'(ocupado), 32'd0);
        chk("midrst_soma", 32'(soma), 32'd0);
        chk("midrst_n_ops", 32'(n_ops), 32'(nops_model));
        waited = 0;
        for (int j = 0; j < 10; j++) begin
            if (pronto || ocupado) waited++;
            tick();
        end
        chk("midrst_abandoned", 32'(waited), 32'd0);

        // Directed decodes
        run_op("pos7", 6'b0_00111, 6'b000111, 1'b0);
        run_op("neg3", 6'b1_00011, 6'b111101, 1'b0);
        run_op("neg24", 6'b1_11000, 6'b101000, 1'b0);
        run_op("negzero", 6'b1_00000, 6'b000000, 1'b0);
        run_op("pos31", 6'b0_11111, 6'b011111, 1'b0);
        run_op("neg31", 6'b1_11111, 6'b100001, 1'b0);
        run_op("ignored_start", 6'b0_00101, 6'b000101, 1'b1);
        for (int i = 0; i < 4; i++) begin
            r = (N+1)'($urandom_range(0, 63));
            run_op("rand", r, ref_decode(r), 1'b0);
        end

        // Back-to-back with iniciar held high for 30 cycles
        result_sm = 6'b1_00101;
        iniciar   = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            chk("b2b_loadAB", 32'(loadAB), 32'(c % 9 == 1));
            chk("b2b_pronto", 32'(pronto), 32'(c % 9 == 8));
            if (loadAB) sb_q.push_back(6'b111011);
            if (pronto) handle_done("b2b");
            if (c == 30) iniciar = 1'b0;
            tick();
        end
        for (int j = 0; j < 20; j++) begin
            if (pronto) handle_done("b2b_drain");
            if (!ocupado && sb_q.size() == 0) break;
            tick();
        end
        chk("b2b_drained_q", 32'(sb_q.size()), 32'd0);
        chk("b2b_drained_idle", 32'(ocupado), 32'd0);

        // Counter wrap after 256 operations
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        nops_model = 8'd0;
        sb_q.delete();
        chk("wrap_start_n_ops", 32'(n_ops), 32'd0);
        result_sm = 6'b0_01010;
        for (int i = 1; i <= 256; i++) begin
            iniciar = 1'b1;
            tick();
            iniciar = 1'b0;
            waited = 0;
            while (!pronto && waited < 12) begin
                tick();
                waited++;
            end
            if (!pronto) begin
                chk("wrap_timeout", 32'(pronto), 32'd1);
                break;
            end
            nops_model = nops_model + 8'd1;
            if (i == 255) chk("wrap_255", 32'(n_ops), 32'd255);
            if (i == 256) begin
                chk("wrap_256", 32'(n_ops), 32'd0);
                chk("wrap_model", 32'(n_ops), 32'(nops_model));
                chk("wrap_soma", 32'(soma), 32'd10);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
